// File: rtl/tl_pkg.sv
// tl_pkg: shared state encoding and default phase durations for traffic_light
package tl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_R1G = 3'd0;
  localparam state_t S_R1Y = 3'd1;
  localparam state_t S_R2G = 3'd2;
  localparam state_t S_R2Y = 3'd3;
  localparam state_t S_FG  = 3'd4;
  localparam state_t S_FY  = 3'd5;
  localparam int G_TIME_D = 8;
  localparam int Y_TIME_D = 2;
  localparam int F_TIME_D = 6;
  localparam int CNT_W_D  = 4;
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: phase counter, counts 0..dur-1 and reloads 0 as done fires
//   clk, rst_n : clock, async active-low reset
//   dur        : length of the current phase in cycles
//   done       : high in the last cycle of the phase
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  assign done = cnt == dur - CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= done ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/traffic_light.sv
// traffic_light: two-road intersection controller with on-demand pedestrian phase
//   clk, rst_n      : clock, async active-low reset
//   c               : pedestrian request level
//   R1G/R1Y/R1R     : road 1 lamps
//   R2G/R2Y/R2R     : road 2 lamps
//   FG/FY/FR        : pedestrian lamps
module traffic_light
  import tl_pkg::*;
#(
  parameter int G_TIME = G_TIME_D,
  parameter int Y_TIME = Y_TIME_D,
  parameter int F_TIME = F_TIME_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c,
  output logic R1G,
  output logic R1Y,
  output logic R1R,
  output logic R2G,
  output logic R2Y,
  output logic R2R,
  output logic FG,
  output logic FY,
  output logic FR
);
  state_t           state, nxt;
  logic             ped_req, done, ped_phase;
  logic [CNT_W-1:0] dur;
  assign ped_phase = state == S_FG || state == S_FY;
  assign dur = (state == S_R1G || state == S_R2G) ? CNT_W'(G_TIME) :
               state == S_FG ? CNT_W'(F_TIME) : CNT_W'(Y_TIME);
  always_comb
    nxt = state == S_R1G ? S_R1Y :
          state == S_R1Y ? S_R2G :
          state == S_R2G ? S_R2Y :
          state == S_R2Y ? (ped_req ? S_FG : S_R1G) :
          state == S_FG  ? S_FY : S_R1G;
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .dur  (dur),
    .done (done)
  );
  // entering the pedestrian phase consumes the request, even if c is high that cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_R1G;
      ped_req <= 1'b0;
    end else begin
      state   <= done ? nxt : state;
      ped_req <= (done && nxt == S_FG) ? 1'b0 : (c && !ped_phase) ? 1'b1 : ped_req;
    end
  // reds are derived so every light always shows exactly one lamp
  assign R1G = state == S_R1G;
  assign R1Y = state == S_R1Y;
  assign R1R = !(R1G || R1Y);
  assign R2G = state == S_R2G;
  assign R2Y = state == S_R2Y;
  assign R2R = !(R2G || R2Y);
  assign FG  = state == S_FG;
  assign FY  = state == S_FY;
  assign FR  = !(FG || FY);
endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: table-driven check of the traffic_light phase sequence
module tb_traffic_light;
  // {R1G,R1Y,R1R, R2G,R2Y,R2R, FG,FY,FR}
  localparam logic [8:0] L_R1G = 9'b100_001_001;
  localparam logic [8:0] L_R1Y = 9'b010_001_001;
  localparam logic [8:0] L_R2G = 9'b001_100_001;
  localparam logic [8:0] L_R2Y = 9'b001_010_001;
  localparam logic [8:0] L_FG  = 9'b001_001_100;
  localparam logic [8:0] L_FY  = 9'b001_001_010;
  typedef struct {
    logic       c;
    int         n;
    logic [8:0] exp;
  } seg_t;
  seg_t tbl[$];
  int tests = 0, fails = 0, idx_b;
  logic clk = 1'b0, rst_n = 1'b0, c = 1'b0;
  logic R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR;
  traffic_light dut (
    .clk(clk), .rst_n(rst_n), .c(c),
    .R1G(R1G), .R1Y(R1Y), .R1R(R1R),
    .R2G(R2G), .R2Y(R2Y), .R2R(R2R),
    .FG(FG), .FY(FY), .FR(FR)
  );
  always #5 clk = ~clk;
  function automatic void add(input logic cv, input int n, input logic [8:0] e);
    seg_t s;
    s.c = cv;
    s.n = n;
    s.exp = e;
    tbl.push_back(s);
  endfunction
  task automatic chk(input string nm, input logic [8:0] exp);
    logic [8:0] act;
    logic [2:0] act_on;
    act = {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR};
    act_on = {R1G | R1Y, R2G | R2Y, FG | FY};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lamps: got %b expected %b", nm, act, exp);
    end
    tests++;
    if (!($onehot(act[8:6]) && $onehot(act[5:3]) && $onehot(act[2:0]) && $countones(act_on) <= 1)) begin
      fails++;
      $display("FAIL %s safety: got %b expected one lamp per light, one active light", nm, act);
    end
  endtask
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        c = tbl[i].c;
        chk($sformatf("seg%0d cyc%0d", i, k), tbl[i].exp);
        @(posedge clk);
        @(negedge clk);
      end
    c = 1'b0;
  endtask
  initial begin
    // idle cycle, 20 cycles
    add(0, 8, L_R1G); add(0, 2, L_R1Y); add(0, 8, L_R2G); add(0, 2, L_R2Y);
    // single-cycle pulse during R1G -> one 28-cycle cycle with pedestrian phase
    add(1, 1, L_R1G); add(0, 7, L_R1G); add(0, 2, L_R1Y); add(0, 8, L_R2G); add(0, 2, L_R2Y);
    add(0, 6, L_FG);  add(0, 2, L_FY);
    // c held 20 cycles across FG entry: served once, re-latched in the R1G after FY
    add(0, 8, L_R1G); add(0, 2, L_R1Y); add(0, 4, L_R2G); add(1, 4, L_R2G); add(1, 2, L_R2Y);
    add(1, 6, L_FG);  add(1, 2, L_FY);  add(1, 6, L_R1G); add(0, 2, L_R1G); add(0, 2, L_R1Y);
    add(0, 8, L_R2G); add(0, 2, L_R2Y); add(0, 6, L_FG);  add(0, 2, L_FY);
    // no request left: plain cycle
    add(0, 8, L_R1G); add(0, 2, L_R1Y); add(0, 8, L_R2G); add(0, 2, L_R2Y);
    // c held continuously: pedestrian phase every cycle
    add(1, 8, L_R1G); add(1, 2, L_R1Y); add(1, 8, L_R2G); add(1, 2, L_R2Y); add(1, 6, L_FG);
    add(1, 2, L_FY);  add(1, 8, L_R1G); add(1, 2, L_R1Y); add(1, 8, L_R2G); add(1, 2, L_R2Y);
    add(1, 6, L_FG);  add(1, 2, L_FY);
    // request raised mid-R2G, then lost to the async reset below
    add(0, 8, L_R1G); add(0, 2, L_R1Y); add(0, 4, L_R2G); add(1, 1, L_R2G);
    idx_b = tbl.size();
    // after reset: full-length R1G, no pedestrian phase
    add(0, 8, L_R1G); add(0, 2, L_R1Y); add(0, 8, L_R2G); add(0, 2, L_R2Y); add(0, 8, L_R1G);
    repeat (2) @(negedge clk);
    chk("in_reset", L_R1G);
    rst_n = 1'b1;
    run_range(0, idx_b);
    // now mid-R2G with ped_req pending; drop reset away from any clock edge
    chk("pre_async", L_R2G);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", L_R1G);
    @(negedge clk);
    chk("held_reset", L_R1G);
    rst_n = 1'b1;
    run_range(idx_b, tbl.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
